// File: rtl/generic_io_dft_out_seq.sv
// Sequencer for the output-IO DFT loopback test: drives en/start, waits out the feedback flush,
// captures the MISR signature and grades it against a golden value. Loop mode: GENERIC_IO_DFT_OUT_SEQ_LOOP_EN.
module generic_io_dft_out_seq #(
   parameter int MISR_LFSR_DW = 8,
   parameter int CNT_W        = 16,
   parameter int SETTLE_CYC   = 4,
   parameter int FLUSH_CYC    = 8,
   parameter int ACT_TMO      = 16
) (
   input  logic                    func_clk,
   input  logic                    func_rst,
   input  logic                    seq_go,
   input  logic                    seq_abort,
   input  logic                    seq_loop,
   input  logic [CNT_W-1:0]        seq_run_len,
   input  logic [MISR_LFSR_DW-1:0] seq_golden,
   input  logic                    io_dft_out_active,
   input  logic [MISR_LFSR_DW-1:0] io_dft_out_misr,
   output logic                    bcfg_io_dft_out_en,
   output logic                    bcfg_io_dft_out_start,
   output logic                    seq_busy,
   output logic                    seq_done,
   output logic                    seq_pass,
   output logic                    seq_fail,
   output logic                    seq_err_tmo,
   output logic [MISR_LFSR_DW-1:0] seq_misr_cap,
   output logic [15:0]             seq_iter_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENABLE  = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;
   localparam logic [2:0] S_DISABLE = 3'd6;

   localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYC - 1);
   localparam logic [4:0] FLUSH_LAST  = 5'(FLUSH_CYC - 1);
   localparam logic [4:0] TMO_LAST    = 5'(ACT_TMO - 1);

   logic [2:0]              state_q, state_d;
   logic [4:0]              tmr_q, tmr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        run_len_q, run_len_d;
   logic [MISR_LFSR_DW-1:0] golden_q, golden_d;
   logic [MISR_LFSR_DW-1:0] misr_cap_q, misr_cap_d;
   logic                    en_q, en_d, start_q, start_d, busy_q, busy_d, done_q, done_d;
   logic                    pass_q, pass_d, fail_q, fail_d, err_tmo_q, err_tmo_d;
   logic [15:0]             iter_q, iter_d;
   logic                    match;

   assign match = (io_dft_out_misr == golden_q);

   always_comb begin
      state_d    = state_q;
      tmr_d      = (tmr_q == 5'h1f) ? tmr_q : tmr_q + 5'd1;
      cnt_d      = cnt_q;
      run_len_d  = run_len_q;
      golden_d   = golden_q;
      misr_cap_d = misr_cap_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      err_tmo_d  = err_tmo_q;
      iter_d     = iter_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (seq_go && !seq_abort) begin
               state_d    = S_ENABLE;
               pass_d     = 1'b0;
               fail_d     = 1'b0;
               err_tmo_d  = 1'b0;
               misr_cap_d = '0;
               run_len_d  = seq_run_len;
               golden_d   = seq_golden;
               iter_d     = '0;
            end
         end
         S_ENABLE: begin
            if (io_dft_out_active) begin
               state_d = S_SETTLE;
               tmr_d   = '0;
            end else if (tmr_q == TMO_LAST) begin
               state_d   = S_DISABLE;
               tmr_d     = '0;
               fail_d    = 1'b1;
               err_tmo_d = 1'b1;
            end
         end
         S_SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               tmr_d   = '0;
               cnt_d   = run_len_q;
               state_d = (run_len_q == '0) ? S_FLUSH : S_RUN;
            end
         end
         S_RUN: begin
            // cnt_q is never 0 here; <= keeps the exit safe without wrapping
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_FLUSH;
               tmr_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FLUSH: begin
            if (tmr_q == FLUSH_LAST) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            misr_cap_d = io_dft_out_misr;
            pass_d     = match;
            fail_d     = !match;
            tmr_d      = '0;
            state_d    = S_DISABLE;
`ifdef GENERIC_IO_DFT_OUT_SEQ_LOOP_EN
            if (match && seq_loop) begin
               state_d   = S_SETTLE;
               run_len_d = seq_run_len;
               golden_d  = seq_golden;
               iter_d    = (iter_q == 16'hFFFF) ? iter_q : iter_q + 16'd1;
            end
`endif
         end
         S_DISABLE: begin
            if (!io_dft_out_active) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (tmr_q == TMO_LAST) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               fail_d    = 1'b1;
               err_tmo_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort freezes status and heads for DISABLE; once there the normal exit proceeds
      if (seq_abort && state_q != S_IDLE && state_q != S_DISABLE) begin
         state_d    = S_DISABLE;
         tmr_d      = '0;
         cnt_d      = cnt_q;
         run_len_d  = run_len_q;
         golden_d   = golden_q;
         misr_cap_d = misr_cap_q;
         pass_d     = pass_q;
         fail_d     = fail_q;
         err_tmo_d  = err_tmo_q;
         iter_d     = iter_q;
      end
      en_d    = (state_d == S_ENABLE) || (state_d == S_SETTLE) || (state_d == S_RUN) ||
                (state_d == S_FLUSH) || (state_d == S_CAPTURE);
      start_d = (state_d == S_RUN);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge func_clk or posedge func_rst) begin
      if (func_rst) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         cnt_q      <= '0;
         run_len_q  <= '0;
         golden_q   <= '0;
         misr_cap_q <= '0;
         en_q       <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         err_tmo_q  <= 1'b0;
         iter_q     <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         run_len_q  <= run_len_d;
         golden_q   <= golden_d;
         misr_cap_q <= misr_cap_d;
         en_q       <= en_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         err_tmo_q  <= err_tmo_d;
         iter_q     <= iter_d;
      end
   end

   assign bcfg_io_dft_out_en    = en_q;
   assign bcfg_io_dft_out_start = start_q;
   assign seq_busy              = busy_q;
   assign seq_done              = done_q;
   assign seq_pass              = pass_q;
   assign seq_fail              = fail_q;
   assign seq_err_tmo           = err_tmo_q;
   assign seq_misr_cap          = misr_cap_q;

`ifdef GENERIC_IO_DFT_OUT_SEQ_LOOP_EN
   assign seq_iter_cnt = iter_q;
`else
   logic unused_loop;
   assign unused_loop  = seq_loop ^ (|iter_q);
   assign seq_iter_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_generic_io_dft_out_seq.sv
// Directed bench for generic_io_dft_out_seq: active echoes en with 2 cycles of delay, MISR is a driven constant.
module tb_generic_io_dft_out_seq;
   logic        func_clk = 1'b0;
   logic        func_rst, seq_go, seq_abort, seq_loop;
   logic [15:0] seq_run_len;
   logic [7:0]  seq_golden, io_dft_out_misr, seq_misr_cap;
   logic        io_dft_out_active, en, start, seq_busy, seq_done, seq_pass, seq_fail, seq_err_tmo;
   logic [15:0] seq_iter_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   generic_io_dft_out_seq dut (
      .func_clk(func_clk), .func_rst(func_rst), .seq_go(seq_go), .seq_abort(seq_abort),
      .seq_loop(seq_loop), .seq_run_len(seq_run_len), .seq_golden(seq_golden),
      .io_dft_out_active(io_dft_out_active), .io_dft_out_misr(io_dft_out_misr),
      .bcfg_io_dft_out_en(en), .bcfg_io_dft_out_start(start), .seq_busy(seq_busy),
      .seq_done(seq_done), .seq_pass(seq_pass), .seq_fail(seq_fail), .seq_err_tmo(seq_err_tmo),
      .seq_misr_cap(seq_misr_cap), .seq_iter_cnt(seq_iter_cnt));

   always #5 func_clk = ~func_clk;

   // active model: en delayed by two clocks, or held low
   logic       act_tie0 = 1'b0;
   logic [1:0] act_pipe;
   always @(posedge func_clk or posedge func_rst)
      if (func_rst) act_pipe <= 2'b00;
      else          act_pipe <= {act_pipe[0], en};
   assign io_dft_out_active = act_tie0 ? 1'b0 : act_pipe[1];

   int   cyc = 0, start_cnt, en_cnt, done_cnt, en_rise, start_rise;
   logic en_prev = 1'b0, start_prev = 1'b0;
   always @(posedge func_clk) begin
      cyc++;
      if (start) start_cnt++;
      if (en) en_cnt++;
      if (seq_done) done_cnt++;
      if (en && !en_prev && en_rise < 0) en_rise = cyc;
      if (start && !start_prev && start_rise < 0) start_rise = cyc;
      en_prev    = en;
      start_prev = start;
   end

   task automatic clr_mon();
      start_cnt = 0; en_cnt = 0; done_cnt = 0; en_rise = -1; start_rise = -1;
   endtask

   task automatic go_pulse(input logic [7:0] gold, input logic [15:0] len);
      @(negedge func_clk);
      seq_golden = gold; seq_run_len = len; seq_go = 1'b1;
      @(negedge func_clk);
      seq_go = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge func_clk);
         if (!seq_busy) break;
      end
      n_cmp++;
      if (i == bound) begin n_bad++; $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, seq_busy, bound); end
      @(negedge func_clk);
   endtask

   task automatic wait_start(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge func_clk);
         if (start) break;
      end
      n_cmp++;
      if (i == 200) begin n_bad++; $display("FAIL %s_start_timeout: start=%b, expected 1", name, start); end
   endtask

   task automatic test_reset();
      func_rst = 1'b1;
      #12;
      n_cmp++; if ({en, start, seq_busy, seq_done} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl: got %b expected 0000", {en, start, seq_busy, seq_done}); end
      n_cmp++; if ({seq_pass, seq_fail, seq_err_tmo} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b expected 000", {seq_pass, seq_fail, seq_err_tmo}); end
      n_cmp++; if ({seq_misr_cap, seq_iter_cnt} !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {seq_misr_cap, seq_iter_cnt}); end
      @(negedge func_clk);
      func_rst = 1'b0;
   endtask

   task automatic test_pass();
      clr_mon(); io_dft_out_misr = 8'hA5;
      go_pulse(8'hA5, 16'd100);
      wait_idle("pass", 400);
      n_cmp++; if (start_cnt !== 100) begin n_bad++; $display("FAIL pass_start_len: got %0d expected 100", start_cnt); end
      // en rise -> 3 ENABLE cycles (2-cycle echo, sampled next edge) + 4 SETTLE cycles
      n_cmp++; if (start_rise - en_rise !== 7) begin n_bad++; $display("FAIL pass_start_latency: got %0d expected 7", start_rise - en_rise); end
      n_cmp++; if ({seq_pass, seq_fail, seq_err_tmo} !== 3'b100) begin n_bad++; $display("FAIL pass_status: got %b expected 100", {seq_pass, seq_fail, seq_err_tmo}); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL pass_done: got %0d expected 1", done_cnt); end
      n_cmp++; if (seq_misr_cap !== 8'hA5) begin n_bad++; $display("FAIL pass_misr_cap: got %h expected a5", seq_misr_cap); end
   endtask

   task automatic test_golden_mismatch();
      clr_mon(); io_dft_out_misr = 8'hA5;
      go_pulse(8'h5A, 16'd100);
      wait_idle("mismatch", 400);
      n_cmp++; if ({seq_pass, seq_fail, seq_err_tmo} !== 3'b010) begin n_bad++; $display("FAIL mismatch_status: got %b expected 010", {seq_pass, seq_fail, seq_err_tmo}); end
      n_cmp++; if (seq_misr_cap !== 8'hA5) begin n_bad++; $display("FAIL mismatch_misr_cap: got %h expected a5", seq_misr_cap); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL mismatch_done: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_timeout();
      clr_mon(); act_tie0 = 1'b1;
      go_pulse(8'hA5, 16'd100);
      wait_idle("tmo", 100);
      n_cmp++; if (en_cnt !== 16) begin n_bad++; $display("FAIL tmo_en_cycles: got %0d expected 16", en_cnt); end
      n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL tmo_start: got %0d expected 0", start_cnt); end
      n_cmp++; if ({seq_pass, seq_fail, seq_err_tmo} !== 3'b011) begin n_bad++; $display("FAIL tmo_status: got %b expected 011", {seq_pass, seq_fail, seq_err_tmo}); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL tmo_done: got %0d expected 1", done_cnt); end
      act_tie0 = 1'b0;
   endtask

   task automatic test_zero_len();
      clr_mon(); io_dft_out_misr = 8'h01;
      go_pulse(8'h01, 16'd0);
      wait_idle("zero", 200);
      n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL zero_start: got %0d expected 0", start_cnt); end
      n_cmp++; if ({seq_pass, seq_fail, seq_err_tmo} !== 3'b100) begin n_bad++; $display("FAIL zero_status: got %b expected 100", {seq_pass, seq_fail, seq_err_tmo}); end
      n_cmp++; if (seq_misr_cap !== 8'h01) begin n_bad++; $display("FAIL zero_misr_cap: got %h expected 01", seq_misr_cap); end
   endtask

   task automatic test_abort();
      clr_mon(); io_dft_out_misr = 8'hA5;
      go_pulse(8'hA5, 16'd100);
      wait_start("abort");
      repeat (49) @(negedge func_clk);
      seq_abort = 1'b1;
      @(negedge func_clk);
      seq_abort = 1'b0;
      n_cmp++; if ({en, start} !== 2'b00) begin n_bad++; $display("FAIL abort_drop: got %b expected 00", {en, start}); end
      wait_idle("abort", 100);
      n_cmp++; if (start_cnt !== 50) begin n_bad++; $display("FAIL abort_start_len: got %0d expected 50", start_cnt); end
      n_cmp++; if ({seq_pass, seq_fail, seq_misr_cap} !== 10'h0) begin n_bad++; $display("FAIL abort_status: got %h expected 0", {seq_pass, seq_fail, seq_misr_cap}); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL abort_done: got %0d expected 1", done_cnt); end
      // rerun; a go issued mid-run must be ignored
      clr_mon();
      go_pulse(8'hA5, 16'd10);
      wait_start("rerun");
      go_pulse(8'h00, 16'd3);
      wait_idle("rerun", 200);
      n_cmp++; if (start_cnt !== 10) begin n_bad++; $display("FAIL rerun_start_len: got %0d expected 10", start_cnt); end
      n_cmp++; if ({seq_pass, seq_fail} !== 2'b10) begin n_bad++; $display("FAIL rerun_status: got %b expected 10", {seq_pass, seq_fail}); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rerun_done: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_go_with_abort();
      @(negedge func_clk);
      seq_go = 1'b1; seq_abort = 1'b1;
      @(negedge func_clk);
      seq_go = 1'b0; seq_abort = 1'b0;
      n_cmp++; if ({seq_busy, en} !== 2'b00) begin n_bad++; $display("FAIL go_abort_idle: got %b expected 00", {seq_busy, en}); end
   endtask

   task automatic test_async_reset();
      io_dft_out_misr = 8'hA5;
      go_pulse(8'hA5, 16'd100);
      wait_start("arst");
      repeat (10) @(negedge func_clk);
      @(posedge func_clk);
      #2 func_rst = 1'b1;
      #1;
      n_cmp++; if ({en, start, seq_busy, seq_done, seq_pass, seq_fail} !== 6'b0) begin n_bad++; $display("FAIL arst_outputs: got %b expected 000000", {en, start, seq_busy, seq_done, seq_pass, seq_fail}); end
      @(negedge func_clk);
      func_rst = 1'b0;
   endtask

   task automatic test_loop();
      clr_mon(); io_dft_out_misr = 8'hA5; seq_loop = 1'b1;
      go_pulse(8'hA5, 16'd5);
`ifdef GENERIC_IO_DFT_OUT_SEQ_LOOP_EN
      begin
         int i;
         int en_gap = 0;
         for (i = 0; i < 500; i++) begin
            @(negedge func_clk);
            if (en_rise >= 0 && !en) en_gap++;
            if (seq_iter_cnt == 16'd3) break;
         end
         n_cmp++; if (i == 500) begin n_bad++; $display("FAIL loop_iter_timeout: got %0d expected 3", seq_iter_cnt); end
         n_cmp++; if (en_gap !== 0) begin n_bad++; $display("FAIL loop_en_gap: got %0d low cycles expected 0", en_gap); end
         n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL loop_early_done: got %0d expected 0", done_cnt); end
         seq_loop = 1'b0;
         wait_idle("loop", 200);
         n_cmp++; if (seq_iter_cnt !== 16'd3) begin n_bad++; $display("FAIL loop_iter_final: got %0d expected 3", seq_iter_cnt); end
      end
`else
      seq_loop = 1'b1;
      wait_idle("loop", 200);
      n_cmp++; if (seq_iter_cnt !== 16'd0) begin n_bad++; $display("FAIL loop_iter_tied: got %0d expected 0", seq_iter_cnt); end
`endif
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL loop_done: got %0d expected 1", done_cnt); end
      n_cmp++; if ({seq_pass, seq_fail} !== 2'b10) begin n_bad++; $display("FAIL loop_status: got %b expected 10", {seq_pass, seq_fail}); end
      seq_loop = 1'b0;
   endtask

   initial begin
      seq_go = 1'b0; seq_abort = 1'b0; seq_loop = 1'b0;
      seq_run_len = '0; seq_golden = '0; io_dft_out_misr = '0;
      test_reset();
      test_pass();
      test_golden_mismatch();
      test_timeout();
      test_zero_len();
      test_abort();
      test_go_with_abort();
      test_async_reset();
      test_loop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
